// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, load-type codes and extension helpers for the pipeline
package pipeline_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [2:0] load_type_t;

   localparam load_type_t LT_W  = 3'd0;
   localparam load_type_t LT_H  = 3'd1;
   localparam load_type_t LT_HU = 3'd2;
   localparam load_type_t LT_B  = 3'd3;
   localparam load_type_t LT_BU = 3'd4;

   function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic sgn);
      return {{(DATA_W-8){sgn & b[7]}}, b};
   endfunction

   function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic sgn);
      return {{(DATA_W-16){sgn & h[15]}}, h};
   endfunction

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - little-endian byte/halfword select with sign or zero extension
module wb_load_align
   import pipeline_pkg::*;
(
   input  load_type_t        load_type_i,
   input  logic [1:0]        byte_off_i,
   input  logic [DATA_W-1:0] word_i,
   output logic [DATA_W-1:0] aligned_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (byte_off_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      // Halfword loads ignore byte_off[0]; misalignment is not trapped here.
      half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      aligned_o = word_i;
      case (load_type_i)
         LT_B:    aligned_o = ext8(byte_sel, 1'b1);
         LT_BU:   aligned_o = ext8(byte_sel, 1'b0);
         LT_H:    aligned_o = ext16(half_sel, 1'b1);
         LT_HU:   aligned_o = ext16(half_sel, 1'b0);
         default: aligned_o = word_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, writeback mux, register-file write port and commit counter
// Optional write-first bypass to the ID-stage read ports when WB_BYPASS_EN is defined.
module wb_stage
   import pipeline_pkg::load_type_t;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              mem_reg_write,
   input  logic              mem_mem_to_reg,
   input  load_type_t        mem_load_type,
   input  logic [1:0]        mem_byte_off,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [ADDR_W-1:0] mem_write_address,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] write_data,
   output logic              reg_write,
   output logic [CNT_W-1:0]  wb_count,
   input  logic [ADDR_W-1:0] read_addr_a,
   input  logic [ADDR_W-1:0] read_addr_b,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   output logic [DATA_W-1:0] bypass_a,
   output logic [DATA_W-1:0] bypass_b
);

   logic              valid_q,      valid_d;
   logic              reg_write_q,  reg_write_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   load_type_t        load_type_q,  load_type_d;
   logic [1:0]        byte_off_q,   byte_off_d;
   logic [DATA_W-1:0] alu_q,        alu_d;
   logic [DATA_W-1:0] rdata_q,      rdata_d;
   logic [ADDR_W-1:0] waddr_q,      waddr_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;

   logic [DATA_W-1:0] load_aligned;

   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      load_type_d  = load_type_q;
      byte_off_d   = byte_off_q;
      alu_d        = alu_q;
      rdata_d      = rdata_q;
      waddr_d      = waddr_q;
      // A flush only needs to kill valid; the payload fields are left as they were.
      if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         valid_d      = 1'b1;
         reg_write_d  = mem_reg_write;
         mem_to_reg_d = mem_mem_to_reg;
         load_type_d  = mem_load_type;
         byte_off_d   = mem_byte_off;
         alu_d        = mem_alu_result;
         rdata_d      = mem_read_data;
         waddr_d      = mem_write_address;
      end
   end

   // The write is counted on the edge it leaves WB, so a stalled write counts once.
   always_comb begin
      cnt_d = cnt_q;
      if (reg_write && !stall) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         load_type_q  <= '0;
         byte_off_q   <= '0;
         alu_q        <= '0;
         rdata_q      <= '0;
         waddr_q      <= '0;
         cnt_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         load_type_q  <= load_type_d;
         byte_off_q   <= byte_off_d;
         alu_q        <= alu_d;
         rdata_q      <= rdata_d;
         waddr_q      <= waddr_d;
         cnt_q        <= cnt_d;
      end
   end

   wb_load_align u_align (
      .load_type_i (load_type_q),
      .byte_off_i  (byte_off_q),
      .word_i      (rdata_q),
      .aligned_o   (load_aligned)
   );

   assign write_address = waddr_q;
   assign write_data    = mem_to_reg_q ? load_aligned : alu_q;
   assign reg_write     = valid_q & reg_write_q & (waddr_q != '0);
   assign wb_count      = cnt_q;

`ifdef WB_BYPASS_EN
   assign bypass_a = (reg_write && (read_addr_a == write_address)) ? write_data : data_a;
   assign bypass_b = (reg_write && (read_addr_b == write_address)) ? write_data : data_b;
`else
   logic unused_read_addr;
   assign unused_read_addr = ^{read_addr_a, read_addr_b};
   assign bypass_a = data_a;
   assign bypass_b = data_b;
`endif

endmodule
